// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory loader.
//   IM_DEPTH_WORDS  default IM capacity in 32-bit words
//   BYTES_PER_WORD  bytes packed into one IM word
//   state_e         loader FSM encodings
// Optional feature macro: IM_LOADER_CKSUM_EN adds the StCheck state.
package im_pkg;

  localparam int unsigned IM_DEPTH_WORDS = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StWrite   = 3'd2,
`ifdef IM_LOADER_CKSUM_EN
    StCheck   = 3'd3,
`endif
    StFin     = 3'd4
  } state_e;

endpackage

// File: rtl/im_word_packer.sv
// Byte-to-word packer: shifts incoming bytes into a big-endian word.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       drop any partial word and restart at byte 0
//   push        one byte accepted this cycle
//   byte_in     byte being accepted
//   word        packed word including byte_in as the least significant byte
//   complete    push of the final byte of a word happens this cycle
module im_word_packer
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        complete
);

  // Only the first three bytes need storing; the fourth is taken straight from byte_in.
  logic [23:0] shift_q;
  logic [1:0]  byte_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (clear) begin
      byte_idx_q <= '0;
    end else if (push) begin
      shift_q    <= {shift_q[15:0], byte_in};
      byte_idx_q <= byte_idx_q + 2'd1;
    end
  end

  assign word     = {shift_q, byte_in};
  assign complete = push && (byte_idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a byte stream into big-endian words and writes them
// into IM while holding the CPU off.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load request, sampled only when idle
//   base_addr    word-aligned byte address of the first word
//   word_count   number of words to load
//   in_valid     byte-stream valid
//   in_data      byte-stream data
//   in_ready     byte accepted when in_valid && in_ready
//   wr_en        IM write strobe, one cycle per word
//   wr_addr      IM byte address of the word
//   wr_data      packed word, first byte in [31:24]
//   busy         high while a load is in progress
//   cpu_hold     copy of busy, stalls pipeline fetch
//   done         one-cycle end-of-load pulse
//   error        one-cycle pulse: rejected request or checksum failure
// Optional feature macro: IM_LOADER_CKSUM_EN appends a trailing checksum byte to each load.
module im_loader
  import im_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = IM_DEPTH_WORDS,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  // Wide enough that base + 4*count can never wrap.
  localparam int unsigned ReqW = (CNT_W + 3 > 34) ? CNT_W + 3 : 34;

  state_e           state_q;
  logic [31:0]      base_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] word_idx_q;
  logic             in_ready_q;
  logic             wr_en_q;
  logic [31:0]      wr_addr_q;
  logic [31:0]      wr_data_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
`ifdef IM_LOADER_CKSUM_EN
  logic [7:0]       sum_q;
`endif

  logic [ReqW-1:0]  req_end;
  logic             req_bad;
  logic             pack_clear;
  logic             pack_push;
  logic [31:0]      pack_word;
  logic             pack_complete;
  logic [31:0]      cur_addr;
  logic             last_word;

  assign req_end = ReqW'(base_addr) + (ReqW'(word_count) << 2);
  assign req_bad = (base_addr[1:0] != 2'b00) ||
                   (req_end > ReqW'(BYTES_PER_WORD * DEPTH_WORDS));

  assign pack_push  = (state_q == StCollect) && in_ready_q && in_valid;
  assign pack_clear = ((state_q == StIdle) && start) || (state_q == StWrite);

  assign cur_addr  = base_q + 32'({word_idx_q, 2'b00});
  assign last_word = (word_idx_q == (count_q - CNT_W'(1)));

  im_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pack_clear),
    .push     (pack_push),
    .byte_in  (in_data),
    .word     (pack_word),
    .complete (pack_complete)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IM_LOADER_CKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (req_bad) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
            end else if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              base_q     <= base_addr;
              count_q    <= word_count;
              word_idx_q <= '0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= StCollect;
`ifdef IM_LOADER_CKSUM_EN
              sum_q      <= '0;
`endif
            end
          end
        end
        StCollect: begin
`ifdef IM_LOADER_CKSUM_EN
          if (pack_push) begin
            sum_q <= sum_q + in_data;
          end
`endif
          if (pack_complete) begin
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b1;
            wr_addr_q  <= cur_addr;
            wr_data_q  <= pack_word;
            state_q    <= StWrite;
          end
        end
        StWrite: begin
          word_idx_q <= word_idx_q + CNT_W'(1);
          if (last_word) begin
`ifdef IM_LOADER_CKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= StCheck;
`else
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFin;
`endif
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= StCollect;
          end
        end
`ifdef IM_LOADER_CKSUM_EN
        StCheck: begin
          if (in_ready_q && in_valid) begin
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            // Data bytes plus checksum byte must sum to zero modulo 256.
            error_q    <= ((sum_q + in_data) != 8'h00);
            state_q    <= StFin;
          end
        end
`endif
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign cpu_hold = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
